multicycle_controller: RTL and testbench

- Control FSM for the multicycle RISC-V datapath, the successor to the single-cycle core.
- Shares one unified instruction/data memory and one ALU across fetch, address, execute and PC-increment steps.
- Sequences every write enable and mux select per cycle, and waits on a memory-ready handshake.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal, and counts retired instructions.

---
 rtl/multicycle_controller.sv | 254 +++++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
//   Control FSM for a multicycle RISC-V datapath. One unified memory and a
//   single ALU are time-shared across fetch, decode, address, execute and
//   write-back steps. The FSM sequences every write enable and mux select and
//   waits on a memory-ready handshake in the memory-access states.
//
// Optional build macro:
//   ILLEGAL_TRAP_EN - when defined, an unrecognised opcode in DECODE traps into
//                     HALT (code 15), raises a sticky 'illegal' flag and stays
//                     there until reset. When undefined, the opcode is dropped
//                     as a no-op (back to FETCH, no retire), 'illegal' is 0.
//
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   op, funct3,funct7b5 instruction fields from the instruction register
//   Zero                ALU zero flag (branch decision)
//   mem_ready           memory finishes the current access this cycle
//   PCWrite..RegWrite   datapath enables and mux selects (combinational)
//   instr_done          one-cycle pulse in the final cycle of an instruction
//   retire_count        registered count of retired instructions (wraps)
//   state               current state code, for debug
//   illegal             sticky illegal-opcode flag (registered)
// -----------------------------------------------------------------------------
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             Zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ImmSrc,
  output logic [2:0]       ALUControl,
  output logic             RegWrite,
  output logic             instr_done,
  output logic [CNT_W-1:0] retire_count,
  output logic [3:0]       state,
  output logic             illegal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_HALT     = 4'd15
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic             illegal_q, illegal_d;

  // Raw enables before the reset gate.
  logic pc_write_s, mem_write_s, ir_write_s, reg_write_s;

  // ALU operation for execute states. Instr[30] only selects sub for R-type
  // (op[5]=1); for I-type it is an immediate bit and must not turn addi into sub.
  function automatic logic [2:0] alu_decode(input logic       op5,
                                            input logic [2:0] f3,
                                            input logic       f7b5);
    logic [2:0] res;
    case (f3)
      3'b000:  res = (f7b5 & op5) ? ALU_SUB : ALU_ADD;
      3'b010:  res = ALU_SLT;
      3'b110:  res = ALU_OR;
      3'b111:  res = ALU_AND;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

  // Immediate format from the opcode, independent of state.
  function automatic logic [1:0] imm_decode(input logic [6:0] opc);
    logic [1:0] res;
    case (opc)
      7'b0100011: res = 2'b01;  // S (sw)
      7'b1100011: res = 2'b10;  // B (beq)
      7'b1101111: res = 2'b11;  // J (jal)
      default:    res = 2'b00;  // I (lw, I-ALU) and don't-care formats
    endcase
    return res;
  endfunction

  // State, retire counter and sticky illegal flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      retire_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retire_q  <= retire_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and per-state control outputs.
  always_comb begin
    state_d     = state_q;
    pc_write_s  = 1'b0;
    AdrSrc      = 1'b0;
    mem_write_s = 1'b0;
    ir_write_s  = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUControl  = ALU_ADD;
    reg_write_s = 1'b0;
    instr_done  = 1'b0;

    case (state_q)
      S_FETCH: begin
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        ir_write_s = mem_ready;
        pc_write_s = mem_ready;
        state_d    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is computed here and parked in ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: state_d = S_MEMADR;
          7'b0110011:             state_d = S_EXECR;
          7'b0010011:             state_d = S_EXECI;
          7'b1100011:             state_d = S_BEQ;
          7'b1101111:             state_d = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:                state_d = S_HALT;
`else
          default:                state_d = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe is held until the memory accepts the write.
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
        instr_done  = mem_ready;
        state_d     = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECR: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = alu_decode(op[5], funct3, funct7b5);
        state_d    = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = alu_decode(op[5], funct3, funct7b5);
        state_d    = S_ALUWB;
      end
      S_ALUWB: begin
        ResultSrc   = 2'b00;
        reg_write_s = 1'b1;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b00;
        ALUControl = ALU_SUB;
        ResultSrc  = 2'b00;
        pc_write_s = Zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JAL: begin
        // Jump to the target held in ALUOut while OldPC+4 is computed for rd;
        // the link write and retire happen in ALUWB.
        ALUSrcA    = 2'b01;
        ALUSrcB    = 2'b10;
        ALUControl = ALU_ADD;
        ResultSrc  = 2'b00;
        pc_write_s = 1'b1;
        state_d    = S_ALUWB;
      end
`ifdef ILLEGAL_TRAP_EN
      S_HALT: begin
        state_d = S_HALT;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Counter and sticky-flag next values.
  always_comb begin
    retire_d = retire_q;
    if (instr_done) begin
      retire_d = retire_q + CNT_W'(1);
    end else begin
      retire_d = retire_q;
    end
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q | (state_d == S_HALT);
`else
    illegal_d = 1'b0;
`endif
  end

  // Write enables are suppressed for as long as reset is asserted.
  assign PCWrite      = pc_write_s  & ~reset;
  assign IRWrite      = ir_write_s  & ~reset;
  assign MemWrite     = mem_write_s & ~reset;
  assign RegWrite     = reg_write_s & ~reset;
  assign ImmSrc       = imm_decode(op);
  assign retire_count = retire_q;
  assign state        = state_q;
  assign illegal      = illegal_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
//   Scoreboard bench. The stimulus process picks instructions by mnemonic,
//   walks a reference model that knows each instruction's step list, and pushes
//   the expected output vector for every cycle. A separate monitor pops and
//   compares on every falling edge. A short directed prologue precedes
//   randomized traffic with random mem_ready stalls and occasional resets.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;
  localparam int CW   = 4;
  localparam int NCYC = 4000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    op = 7'b0110011;
  logic [2:0]    funct3 = 3'b000;
  logic          funct7b5 = 1'b0;
  logic          Zero = 1'b0;
  logic          mem_ready = 1'b1;
  logic          PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal;
  logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]    ALUControl;
  logic [CW-1:0] retire_count;
  logic [3:0]    state;

  multicycle_controller #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ImmSrc(ImmSrc),
    .ALUControl(ALUControl), .RegWrite(RegWrite), .instr_done(instr_done),
    .retire_count(retire_count), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef enum int {
    M_LW, M_SW, M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_RX,
    M_ADDI, M_ANDI, M_ORI, M_SLTI, M_IX, M_BEQ, M_JAL, M_BAD
  } mnem_e;

  typedef struct packed {
    logic [3:0]    st;
    logic          pcw;
    logic          adr;
    logic          mw;
    logic          irw;
    logic [1:0]    rs;
    logic [1:0]    sa;
    logic [1:0]    sb;
    logic [1:0]    imm;
    logic [2:0]    alu;
    logic          rw;
    logic          done;
    logic          ill;
    logic [CW-1:0] rc;
  } obs_t;

  typedef struct {
    mnem_e m;
    bit    f7;
    bit    z;
    int    stall;
  } dir_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_mis = 0;

  // Reference model: current instruction, its step list and progress.
  mnem_e         cur;
  logic [3:0]    steps[$];
  int            idx;
  logic [CW-1:0] m_cnt;
  logic          m_ill;
  logic          m_halt;
  int            halt_cyc;

  function automatic bit is_r(mnem_e m);
    return (m == M_ADD) || (m == M_SUB) || (m == M_AND) || (m == M_OR) ||
           (m == M_SLT) || (m == M_RX);
  endfunction

  function automatic bit is_i(mnem_e m);
    return (m == M_ADDI) || (m == M_ANDI) || (m == M_ORI) || (m == M_SLTI) ||
           (m == M_IX);
  endfunction

  // ALU operation implied by the instruction's meaning.
  function automatic logic [2:0] alu_of(mnem_e m);
    case (m)
      M_SUB:          return 3'b001;
      M_AND, M_ANDI:  return 3'b010;
      M_OR,  M_ORI:   return 3'b011;
      M_SLT, M_SLTI:  return 3'b101;
      default:        return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] imm_of(mnem_e m);
    case (m)
      M_SW:    return 2'b01;
      M_BEQ:   return 2'b10;
      M_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  task automatic build_steps(input mnem_e m);
    steps = {4'd0, 4'd1};
    if (m == M_LW) steps = {steps, 4'd2, 4'd3, 4'd4};
    else if (m == M_SW) steps = {steps, 4'd2, 4'd5};
    else if (is_r(m)) steps = {steps, 4'd6, 4'd8};
    else if (is_i(m)) steps = {steps, 4'd7, 4'd8};
    else if (m == M_BEQ) steps = {steps, 4'd9};
    else if (m == M_JAL) steps = {steps, 4'd10, 4'd8};
  endtask

  // Drive instruction fields for mnemonic m; f7 is used where Instr[30] is free.
  task automatic encode(input mnem_e m, input bit f7);
    logic [2:0] odd_f3[4];
    logic [6:0] o;
    odd_f3[0] = 3'b001; odd_f3[1] = 3'b011; odd_f3[2] = 3'b100; odd_f3[3] = 3'b101;
    funct3   = 3'($urandom_range(0, 7));
    funct7b5 = f7;
    case (m)
      M_LW:   op = 7'b0000011;
      M_SW:   op = 7'b0100011;
      M_ADD:  begin op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; end
      M_SUB:  begin op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1; end
      M_AND:  begin op = 7'b0110011; funct3 = 3'b111; end
      M_OR:   begin op = 7'b0110011; funct3 = 3'b110; end
      M_SLT:  begin op = 7'b0110011; funct3 = 3'b010; end
      M_RX:   begin op = 7'b0110011; funct3 = odd_f3[$urandom_range(0, 3)]; end
      M_ADDI: begin op = 7'b0010011; funct3 = 3'b000; end
      M_ANDI: begin op = 7'b0010011; funct3 = 3'b111; end
      M_ORI:  begin op = 7'b0010011; funct3 = 3'b110; end
      M_SLTI: begin op = 7'b0010011; funct3 = 3'b010; end
      M_IX:   begin op = 7'b0010011; funct3 = odd_f3[$urandom_range(0, 3)]; end
      M_BEQ:  op = 7'b1100011;
      M_JAL:  op = 7'b1101111;
      default: begin
        o = 7'b1111111;
        if ($urandom_range(0, 1) == 1) begin
          do o = 7'($urandom_range(0, 127));
          while (o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
                 o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111);
        end
        op = o;
      end
    endcase
  endtask

  task automatic model_reset();
    idx = 0; m_cnt = '0; m_ill = 1'b0; m_halt = 1'b0; halt_cyc = 0;
  endtask

  // Apply one clock edge to the model using the inputs held across it.
  task automatic advance(input bit p_rst, input bit p_mr);
    logic [3:0] code;
    if (p_rst) begin
      model_reset();
    end else if (m_halt) begin
      halt_cyc++;
    end else begin
      code = steps[idx];
      if (!((code == 4'd0 || code == 4'd3 || code == 4'd5) && !p_mr)) begin
        if (idx == steps.size() - 1) begin
          if (cur != M_BAD) m_cnt = m_cnt + 1'b1;
`ifdef ILLEGAL_TRAP_EN
          else begin m_halt = 1'b1; m_ill = 1'b1; halt_cyc = 0; end
`endif
          idx = 0;
        end else begin
          idx++;
        end
      end
    end
  endtask

  // Expected outputs for the current step under the given inputs.
  function automatic obs_t expect_obs(input logic [3:0] code, input bit rst,
                                      input bit mr, input bit z);
    obs_t e;
    e = '0;
    e.st = code; e.imm = imm_of(cur); e.rc = m_cnt; e.ill = m_ill;
    case (code)
      4'd0:  begin e.sb = 2'b10; e.rs = 2'b10; e.irw = mr; e.pcw = mr; end
      4'd1:  begin e.sa = 2'b01; e.sb = 2'b01; end
      4'd2:  begin e.sa = 2'b10; e.sb = 2'b01; end
      4'd3:  e.adr = 1'b1;
      4'd4:  begin e.rs = 2'b01; e.rw = 1'b1; e.done = 1'b1; end
      4'd5:  begin e.adr = 1'b1; e.mw = 1'b1; e.done = mr; end
      4'd6:  begin e.sa = 2'b10; e.alu = alu_of(cur); end
      4'd7:  begin e.sa = 2'b10; e.sb = 2'b01; e.alu = alu_of(cur); end
      4'd8:  begin e.rw = 1'b1; e.done = 1'b1; end
      4'd9:  begin e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; e.done = 1'b1; end
      4'd10: begin e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1'b1; end
      default: ;
    endcase
    if (rst) begin e.pcw = 1'b0; e.irw = 1'b0; e.mw = 1'b0; e.rw = 1'b0; end
    return e;
  endfunction

  // Stimulus and expectation producer.
  initial begin
    dir_t       dir_q[$];
    int         dptr = 0;
    int         stall_left = 0;
    bit         dir_zero = 1'b0;
    bit         rst, mr, z;
    bit         p_rst = 1'b1, p_mr = 1'b1;
    logic [3:0] code;
    int         v;

    dir_q.push_back('{M_LW,   1'b0, 1'b0, 0});
    dir_q.push_back('{M_SW,   1'b0, 1'b0, 3});
    dir_q.push_back('{M_SUB,  1'b1, 1'b0, 0});
    dir_q.push_back('{M_ADDI, 1'b1, 1'b0, 0});
    dir_q.push_back('{M_ORI,  1'b0, 1'b0, 0});
    dir_q.push_back('{M_SLTI, 1'b1, 1'b0, 0});
    dir_q.push_back('{M_BEQ,  1'b0, 1'b1, 0});
    dir_q.push_back('{M_BEQ,  1'b0, 1'b0, 0});
    dir_q.push_back('{M_JAL,  1'b0, 1'b0, 0});
    for (int k = 0; k < 8; k++) dir_q.push_back('{M_ADD, 1'b0, 1'b0, 0});
    dir_q.push_back('{M_BAD,  1'b0, 1'b0, 0});

    cur = M_ADD;
    build_steps(cur);
    model_reset();

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      advance(p_rst, p_mr);
      #1;
      rst = (cyc < 2) || (m_halt && halt_cyc >= 10) ||
            (dptr >= dir_q.size() && $urandom_range(0, 99) == 0);
      if (rst) model_reset();
      if (!rst && !m_halt && idx == 0) begin
        if (dptr < dir_q.size()) begin
          cur = dir_q[dptr].m;
          encode(cur, dir_q[dptr].f7);
          dir_zero   = dir_q[dptr].z;
          stall_left = dir_q[dptr].stall;
          dptr++;
        end else begin
          v = int'($urandom_range(0, 31));
          cur = (v == 0) ? M_BAD : mnem_e'(v % 15);
          encode(cur, 1'($urandom_range(0, 1)));
        end
        build_steps(cur);
      end
      code = m_halt ? 4'd15 : steps[idx];
      if (dptr <= dir_q.size() && !(dptr == dir_q.size() && idx == 0 && !m_halt && !rst)) begin
        if (code == 4'd5 && stall_left > 0) begin mr = 1'b0; stall_left--; end
        else mr = 1'b1;
        z = dir_zero;
      end else begin
        mr = ($urandom_range(0, 3) != 0);
        z  = 1'($urandom_range(0, 1));
      end
      reset = rst; mem_ready = mr; Zero = z;
      exp_q.push_back(expect_obs(code, rst, mr, z));
      p_rst = rst; p_mr = mr;
    end

    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++;
      $display("FAIL drain: actual %0d expectations left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  // Monitor: compare the DUT against the oldest expectation once per cycle.
  always @(negedge clk) begin
    obs_t act, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act.st = state; act.pcw = PCWrite; act.adr = AdrSrc; act.mw = MemWrite;
      act.irw = IRWrite; act.rs = ResultSrc; act.sa = ALUSrcA; act.sb = ALUSrcB;
      act.imm = ImmSrc; act.alu = ALUControl; act.rw = RegWrite;
      act.done = instr_done; act.ill = illegal; act.rc = retire_count;
      n_cmp++;
      if (act !== e) begin
        n_mis++;
        $display("FAIL ctrl t=%0t op=%b f3=%b f7=%b mr=%b rst=%b: actual st=%0d pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b imm=%b alu=%b rw=%b done=%b ill=%b rc=%0d, required st=%0d pcw=%b adr=%b mw=%b irw=%b rs=%b sa=%b sb=%b imm=%b alu=%b rw=%b done=%b ill=%b rc=%0d",
                 $time, op, funct3, funct7b5, mem_ready, reset,
                 act.st, act.pcw, act.adr, act.mw, act.irw, act.rs, act.sa, act.sb,
                 act.imm, act.alu, act.rw, act.done, act.ill, act.rc,
                 e.st, e.pcw, e.adr, e.mw, e.irw, e.rs, e.sa, e.sb,
                 e.imm, e.alu, e.rw, e.done, e.ill, e.rc);
      end
    end
  end

endmodule
